apb_slave_bank: RTL and testbench

//  Parametrised APB slave model and register bank: the successor to the flat
//  APB interface with a constant read value. Sits on the APB side of the
//  AHB-to-APB bridge.

---
 rtl/apb_slave_bank.sv | 133 +++++++++++++
 tb/tb_apb_slave_bank.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_bank.sv
// apb_slave_bank: APB slave with NSLV one-hot selected banks of DEPTH x DW registers.
// Define APB_WAIT_STATE_EN to insert WAIT_CYCLES Pready-low cycles into every ACCESS phase.
module apb_slave_bank #(
    parameter int unsigned    DW          = 32,
    parameter int unsigned    AW          = 32,
    parameter int unsigned    NSLV        = 3,
    parameter int unsigned    DEPTH       = 16,
    parameter int unsigned    WAIT_CYCLES = 2,
    parameter logic [DW-1:0]  RESET_DATA  = DW'(25)
) (
    input  logic            Hclk,
    input  logic            Hresetn,
    input  logic            Pwrite,
    input  logic [NSLV-1:0] Pselx,
    input  logic            Penable,
    input  logic [AW-1:0]   Paddr,
    input  logic [DW-1:0]   Pwdata,
    output logic [DW-1:0]   Prdata,
    output logic            Pready,
    output logic            Pslverr
);

    localparam int unsigned   LSB        = $clog2(DW / 8);
    localparam int unsigned   IDXW       = $clog2(DEPTH);
    localparam logic [AW-1:0] ALIGN_MASK = AW'((64'd1 << LSB) - 64'd1);
    localparam logic [AW-1:0] DEPTH_LIM  = AW'(DEPTH);

    if ((DW % 8) != 0 || WAIT_CYCLES > 15 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
        $error("apb_slave_bank: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t              r_state;
    logic [DW-1:0]       r_mem [NSLV][DEPTH];

    logic                w_sel_any;
    logic                w_onehot;
    logic                w_addr_err;
    logic                w_err;
    logic                w_cnt_zero;
    logic                w_ready;
    logic                w_wr_en;
    logic [IDXW-1:0]     w_idx;
    logic [DW-1:0]       w_rd_mux;

`ifdef APB_WAIT_STATE_EN
    logic [3:0]          r_cnt;
    assign w_cnt_zero = (r_cnt == '0);
`else
    assign w_cnt_zero = 1'b1;
`endif

    assign w_sel_any  = |Pselx;
    assign w_onehot   = w_sel_any && ((Pselx & (Pselx - NSLV'(1))) == '0);
    assign w_addr_err = ((Paddr & ALIGN_MASK) != '0) || ((Paddr >> LSB) >= DEPTH_LIM);
    assign w_err      = w_addr_err || !w_onehot;
    assign w_idx      = Paddr[LSB +: IDXW];

    assign w_ready    = (r_state == ACCESS) && w_cnt_zero;
    assign w_wr_en    = w_ready && Pwrite && !w_err;

    assign Pready     = w_ready;
    assign Pslverr    = w_ready && Penable && w_err;
    assign Prdata     = (w_ready && Penable && !Pwrite && !w_err) ? w_rd_mux : '0;

    always_comb begin
        w_rd_mux = '0;
        for (int unsigned s = 0; s < NSLV; s++) begin
            if (Pselx[s]) begin
                w_rd_mux = w_rd_mux | r_mem[s][w_idx];
            end
        end
    end

    // Completion cycle doubles as the next SETUP decision, so back-to-back transfers skip IDLE.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state <= IDLE;
`ifdef APB_WAIT_STATE_EN
            r_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sel_any && !Penable) begin
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    r_state <= ACCESS;
`ifdef APB_WAIT_STATE_EN
                    r_cnt   <= 4'(WAIT_CYCLES);
`endif
                end
                ACCESS: begin
                    if (!w_cnt_zero) begin
                        if (!Penable || !w_sel_any) begin
                            r_state <= IDLE;
                        end
`ifdef APB_WAIT_STATE_EN
                        r_cnt <= r_cnt - 4'd1;
`endif
                    end else begin
                        r_state <= (w_sel_any && !Penable) ? SETUP : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            for (int unsigned s = 0; s < NSLV; s++) begin
                for (int unsigned d = 0; d < DEPTH; d++) begin
                    r_mem[s][d] <= RESET_DATA;
                end
            end
        end else if (w_wr_en) begin
            for (int unsigned s = 0; s < NSLV; s++) begin
                if (Pselx[s]) begin
                    r_mem[s][w_idx] <= Pwdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_bank.sv
// tb_apb_slave_bank: randomized APB transfers checked against an array model of the register banks.
// Expected wait count follows APB_WAIT_STATE_EN (2 wait cycles when defined, none otherwise).
module tb_apb_slave_bank;

`ifdef APB_WAIT_STATE_EN
    localparam int unsigned EXP_WAITS = 2;
`else
    localparam int unsigned EXP_WAITS = 0;
`endif
    localparam int unsigned NS = 3;
    localparam int unsigned ND = 16;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic        Pwrite;
    logic [2:0]  Pselx;
    logic        Penable;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;

    int n_checks = 0;
    int n_errs   = 0;
    logic [31:0] model [NS][ND];

    apb_slave_bank #(
        .DW(32), .AW(32), .NSLV(3), .DEPTH(16), .WAIT_CYCLES(2), .RESET_DATA(32'd25)
    ) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .Pwrite(Pwrite), .Pselx(Pselx), .Penable(Penable),
        .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
    );

    always #5 Hclk = ~Hclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++)
            for (int d = 0; d < ND; d++)
                model[s][d] = 32'd25;
    endtask

    // from_setup: DUT already in SETUP; chain_next: present next SETUP during this completion.
    task automatic apb_xfer(input logic [2:0] sel, input logic [31:0] addr, input logic wr,
                            input logic [31:0] wd, input bit from_setup, input bit chain_next);
        bit          err;
        bit          done;
        int unsigned slv;
        int unsigned waits;
        logic [31:0] exp_rd;
        err = ($countones(sel) != 1) || (addr % 4 != 0) || (addr / 4 >= ND);
        slv = 0;
        for (int s = 0; s < NS; s++) if (sel[s]) slv = s;
        exp_rd = (!wr && !err) ? model[slv][addr / 4] : 32'd0;

        Pselx = sel; Paddr = addr; Pwrite = wr; Pwdata = wd; Penable = 1'b0;
        if (!from_setup) begin
            @(posedge Hclk); #1;
        end
        Penable = 1'b1;
        @(negedge Hclk);
        check_eq("setup_pready", Pready, 1'b0);
        @(posedge Hclk);
        waits = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge Hclk);
            if (Pready) done = 1;
            else waits++;
        end
        check_eq("pready_seen", done, 1'b1);
        check_eq("wait_cycles", waits, EXP_WAITS);
        check_eq("pslverr", Pslverr, err);
        check_eq("prdata", Prdata, exp_rd);
        if (wr && !err) model[slv][addr / 4] = wd;

        if (chain_next) begin
            Penable = 1'b0;
            @(posedge Hclk); #1;
        end else begin
            @(posedge Hclk); #1;
            Pselx = '0; Penable = 1'b0;
        end
    endtask

    initial begin
        logic [2:0]  sel;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wd;
        bit          chained;
        bit          nxt;

        Hresetn = 1'b0; Pwrite = 0; Pselx = '0; Penable = 0; Paddr = '0; Pwdata = '0;
        model_reset();
        repeat (3) @(negedge Hclk);
        check_eq("rst_pready", Pready, 1'b0);
        check_eq("rst_pslverr", Pslverr, 1'b0);
        check_eq("rst_prdata", Prdata, 32'd0);
        Hresetn = 1'b1;
        @(posedge Hclk); #1;

        apb_xfer(3'b001, 32'h0, 0, 0, 0, 0);
        apb_xfer(3'b010, 32'h8, 1, 32'hDEADBEEF, 0, 0);
        apb_xfer(3'b010, 32'h8, 0, 0, 0, 0);
        apb_xfer(3'b001, 32'h8, 0, 0, 0, 0);
        apb_xfer(3'b100, 32'h8, 0, 0, 0, 0);
        apb_xfer(3'b001, 32'h2, 0, 0, 0, 0);
        apb_xfer(3'b001, 32'h40, 0, 0, 0, 0);
        apb_xfer(3'b001, 32'h0, 0, 0, 0, 0);
        apb_xfer(3'b011, 32'h8, 1, 32'h11111111, 0, 0);
        apb_xfer(3'b001, 32'h8, 0, 0, 0, 0);
        apb_xfer(3'b010, 32'h8, 0, 0, 0, 0);
        apb_xfer(3'b100, 32'h4, 1, 32'hA5A5_0001, 0, 1);
        apb_xfer(3'b100, 32'h8, 1, 32'h5A5A_0002, 1, 0);
        apb_xfer(3'b100, 32'h4, 0, 0, 0, 1);
        apb_xfer(3'b100, 32'h8, 0, 0, 1, 0);

        Pselx = '0; Penable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Hclk);
            check_eq("penable_nosel_pready", Pready, 1'b0);
        end
        @(posedge Hclk); #1;
        Penable = 1'b0;

`ifdef APB_WAIT_STATE_EN
        Pselx = 3'b001; Paddr = 32'h4; Pwrite = 1; Pwdata = 32'h1234_5678; Penable = 0;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        @(posedge Hclk);
        @(negedge Hclk);
        Penable = 1'b0; Pselx = '0;
        @(negedge Hclk);
        check_eq("abort_pready", Pready, 1'b0);
        @(posedge Hclk); #1;
        apb_xfer(3'b001, 32'h4, 0, 0, 0, 0);
`endif

        chained = 0;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) sel = ($urandom_range(0, 1) == 0) ? 3'b011 : 3'b111;
            else                           sel = 3'b001 << $urandom_range(0, 2);
            case ($urandom_range(0, 9))
                0:       addr = $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
                1:       addr = 32'h40 + $urandom_range(0, 200) * 4;
                default: addr = $urandom_range(0, 15) * 4;
            endcase
            wr  = $urandom_range(0, 1);
            wd  = $urandom();
            nxt = ($urandom_range(0, 2) == 0) && (n != 79);
            apb_xfer(sel, addr, wr, wd, chained, nxt);
            chained = nxt;
        end

        apb_xfer(3'b100, 32'h10, 1, 32'hCAFE_F00D, 0, 0);
        Pselx = 3'b100; Paddr = 32'h10; Pwrite = 1; Pwdata = 32'h0BAD_0BAD; Penable = 0;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        @(posedge Hclk); #2;
        Hresetn = 1'b0;
        #1;
        check_eq("arst_pready", Pready, 1'b0);
        check_eq("arst_pslverr", Pslverr, 1'b0);
        check_eq("arst_prdata", Prdata, 32'd0);
        model_reset();
        Pselx = '0; Penable = 0; Pwrite = 0;
        @(negedge Hclk);
        Hresetn = 1'b1;
        @(posedge Hclk); #1;
        apb_xfer(3'b100, 32'h10, 0, 0, 0, 0);
        apb_xfer(3'b010, 32'h8, 0, 0, 0, 0);
        for (int n = 0; n < 6; n++)
            apb_xfer(3'b001 << $urandom_range(0, 2), $urandom_range(0, 15) * 4, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
